snax_tcdm_responder: RTL and testbench
======================================

# snax_tcdm_responder

Multi-port TCDM responder (slave) answering the accelerator-side TCDM master ports of a SNAX HWPE (e.g. the MAC top) in standalone and block-level benches. It models word-interleaved single-cycle SRAM banks behind per-bank round-robin arbitration. It implements the PULP TCDM handshake: same-cycle `gnt`, and `r_valid`/`r_data` one cycle after grant.

## Interface
- `MP`, 4, number of TCDM slave ports
- `NB_BANKS`, 4, number of banks (power of two, ≥ 1)
- `BANK_WORDS`, 256, 32-bit words per bank (power of two)
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0 (word aligned)

- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `tcdm_req`  in  [MP-1:0]  request per port
- `tcdm_gnt`  out  [MP-1:0]  grant, combinational from req
- `tcdm_add`  in  [MP-1:0][31:0]  byte address
- `tcdm_wen`  in  [MP-1:0]  1 = read, 0 = write
- `tcdm_be`  in  [MP-1:0][3:0]  byte enables (writes)
- `tcdm_data`  in  [MP-1:0][31:0]  write data
- `tcdm_r_data`  out  [MP-1:0][31:0]  read data
- `tcdm_r_valid`  out  [MP-1:0]  response valid
- `oor_o`  out  1  pulse: a granted access was out of range this cycle

## Operation
- Decode per port: `word = (add - BASE_ADDR) >> 2`; `bank = word[log2(NB_BANKS)-1:0]`; `row = word >> log2(NB_BANKS)`. Address bits [1:0] ignored.
- In range iff `add ≥ BASE_ADDR` and `word < NB_BANKS*BANK_WORDS`.
- Per bank: among requesting in-range ports, one round-robin winner per cycle. After a grant, the bank pointer moves to winner+1 mod MP. Pointers reset to 0. Losers see `gnt=0`, must hold the request, and retry next cycle.
- Out-of-range requests: always granted in the same cycle, bypassing arbitration. Writes are dropped. Reads return 32'hDEAD_BEEF. `oor_o` = 1 that cycle.
- Write: only bytes with `be[i]=1` update; other bytes are kept.
- Every grant (read or write) produces exactly one `r_valid` on the same port in the next cycle. Write responses carry `r_data = 0`.
- Memory contents are not reset. Reads of unwritten words return undefined data.

## Timing
- Cycle N: `req && gnt` — access performed at the clock edge ending cycle N.
- Cycle N+1: `r_valid=1`, `r_data` valid. `r_valid=0` in every cycle not following a grant.
- Back-to-back grants on one port give back-to-back `r_valid`. Throughput is 1 access/port/cycle when there are no bank conflicts.
- Simultaneous read and write to the same bank from different ports: serialized by arbitration. A read granted after a write returns the new data.
- Reset values: `r_valid = 0`, `r_data = 0`, `oor_o = 0`, arbitration pointers = 0. `gnt` = 0 while `rst_ni = 0`.
- Reset asserted mid-access: pending response is discarded (`r_valid` forced 0 asynchronously). Memory contents are undefined after reset.
- `req` deasserted without grant: no side effect.

## Structure
- Constants `TCDM_DW = 32` and `TCDM_OOR_DATA = 32'hDEAD_BEEF` go in a shared package `snax_tcdm_pkg`.
- Sub-module `snax_tcdm_rr_arbiter` (MP requests → one-hot grant, pointer register, `en` to advance). Instantiated once per bank.
- Top level holds the decode logic, the bank arrays (behavioural, byte-enable writes), the response registers, and the out-of-range path.

## Test plan
- Single port: write 32'h1234_5678 to `BASE_ADDR+0x10` with be=4'hF, then read it -> `gnt` same cycle, `r_valid` next cycle, `r_data = 32'h1234_5678`.
- Partial write: be=4'b0010 with data 32'hAABB_CCDD over 32'h1111_1111 -> read returns 32'h1111_CC11.
- Bank conflict: all 4 ports request bank 0 every cycle -> grants rotate 0,1,2,3,0; each port gets 1 grant per 4 cycles; no lost or duplicated `r_valid`.
- No conflict: ports 0..3 hit banks 0..3 -> all granted every cycle; 4 `r_valid` per cycle.
- Out-of-range read at `BASE_ADDR + 4*NB_BANKS*BANK_WORDS` -> granted, `oor_o=1`, next cycle `r_data = 32'hDEAD_BEEF`; a read-back shows memory unchanged.
- Reset pulse while a response is pending -> `r_valid` drops to 0 immediately; first grant after reset goes to port 0.

Source files
------------

// File: rtl/snax_tcdm_pkg.sv
// rtl/snax_tcdm_pkg.sv - shared TCDM constants and helpers
package snax_tcdm_pkg;

  localparam int TCDM_DW = 32;
  localparam logic [TCDM_DW-1:0] TCDM_OOR_DATA = 32'hDEAD_BEEF;

  // Index width that stays legal when the counted quantity is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snax_tcdm_rr_arbiter.sv
// rtl/snax_tcdm_rr_arbiter.sv - round-robin arbiter, one-hot grant
module snax_tcdm_rr_arbiter
  import snax_tcdm_pkg::*;
#(
  parameter int MP = 4,
  localparam int PW = idx_width(MP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en,
  input  logic [MP-1:0] req,
  output logic [MP-1:0] gnt,
  output logic [PW-1:0] idx,
  output logic          vld
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] cand;

  // Scan requesters starting at the pointer; the first one found wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = 0; i < MP; i++) begin
      cand = PW'((int'(ptr_q) + i) % MP);
      if (!vld && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        vld       = 1'b1;
      end
    end
  end

  // Next pointer: one past the winner, wrapping at MP.
  always_comb begin
    ptr_d = ptr_q;
    if (en && vld) begin
      ptr_d = (int'(idx) == MP - 1) ? '0 : idx + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/snax_tcdm_responder.sv
// rtl/snax_tcdm_responder.sv - multi-port banked TCDM responder
module snax_tcdm_responder
  import snax_tcdm_pkg::*;
#(
  parameter int          MP         = 4,
  parameter int          NB_BANKS   = 4,
  parameter int          BANK_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [MP-1:0]                 tcdm_req,
  output logic [MP-1:0]                 tcdm_gnt,
  input  logic [MP-1:0][31:0]           tcdm_add,
  input  logic [MP-1:0]                 tcdm_wen,
  input  logic [MP-1:0][3:0]            tcdm_be,
  input  logic [MP-1:0][TCDM_DW-1:0]    tcdm_data,
  output logic [MP-1:0][TCDM_DW-1:0]    tcdm_r_data,
  output logic [MP-1:0]                 tcdm_r_valid,
  output logic                          oor_o
);

  localparam int          PW    = idx_width(MP);
  localparam int          BBW   = idx_width(NB_BANKS);
  localparam int          BSH   = $clog2(NB_BANKS);
  localparam int          RW    = idx_width(BANK_WORDS);
  localparam logic [31:0] DEPTH = 32'(NB_BANKS * BANK_WORDS);

  logic [31:0]        dec_word  [MP];
  logic [MP-1:0]      in_range;
  logic [MP-1:0]      oor_req;
  logic [BBW-1:0]     bank_sel  [MP];
  logic [RW-1:0]      row_sel   [MP];
  logic [MP-1:0]      bank_gnt  [NB_BANKS];
  logic [TCDM_DW-1:0] bank_rd   [NB_BANKS];
  logic [MP-1:0]      mem_gnt;

  // Address decode: word-interleaved banks relative to BASE_ADDR.
  always_comb begin
    in_range = '0;
    oor_req  = '0;
    for (int p = 0; p < MP; p++) begin
      dec_word[p] = (tcdm_add[p] - BASE_ADDR) >> 2;
      in_range[p] = (tcdm_add[p] >= BASE_ADDR) && (dec_word[p] < DEPTH);
      oor_req[p]  = tcdm_req[p] && !in_range[p];
      bank_sel[p] = (NB_BANKS > 1) ? dec_word[p][BBW-1:0] : '0;
      row_sel[p]  = RW'(dec_word[p] >> BSH);
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [MP-1:0]      req_b;
    logic [MP-1:0]      gnt_b;
    logic [PW-1:0]      idx_b;
    logic               vld_b;
    logic [TCDM_DW-1:0] mem [BANK_WORDS];

    // In-range requests targeting this bank; nothing competes during reset.
    always_comb begin
      req_b = '0;
      for (int p = 0; p < MP; p++) begin
        req_b[p] = rst_ni && tcdm_req[p] && in_range[p] && (bank_sel[p] == BBW'(b));
      end
    end

    snax_tcdm_rr_arbiter #(
      .MP (MP)
    ) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en     (1'b1),
      .req    (req_b),
      .gnt    (gnt_b),
      .idx    (idx_b),
      .vld    (vld_b)
    );

    // Byte-enabled write by the bank winner; array contents are never reset.
    always_ff @(posedge clk_i) begin
      if (vld_b && !tcdm_wen[idx_b]) begin
        for (int k = 0; k < 4; k++) begin
          if (tcdm_be[idx_b][k]) begin
            mem[row_sel[idx_b]][8*k +: 8] <= tcdm_data[idx_b][8*k +: 8];
          end
        end
      end
    end

    assign bank_gnt[b] = gnt_b;
    assign bank_rd[b]  = mem[row_sel[idx_b]];
  end

  // Merge per-bank grants back onto the ports.
  always_comb begin
    mem_gnt = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      mem_gnt = mem_gnt | bank_gnt[b];
    end
  end

  // Out-of-range requests bypass arbitration and are always granted.
  always_comb begin
    tcdm_gnt = '0;
    oor_o    = 1'b0;
    if (rst_ni) begin
      tcdm_gnt = mem_gnt | oor_req;
      oor_o    = |oor_req;
    end
  end

  // One response per grant, one cycle later; writes answer with zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcdm_r_valid <= '0;
      tcdm_r_data  <= '0;
    end else begin
      for (int p = 0; p < MP; p++) begin
        tcdm_r_valid[p] <= tcdm_gnt[p];
        if (tcdm_gnt[p] && tcdm_wen[p]) begin
          tcdm_r_data[p] <= oor_req[p] ? TCDM_OOR_DATA : bank_rd[bank_sel[p]];
        end else begin
          tcdm_r_data[p] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// tb/tb_snax_tcdm_responder.sv - directed bench for snax_tcdm_responder
module tb_snax_tcdm_responder;

  logic             clk_i;
  logic             rst_ni;
  logic [3:0]       tcdm_req;
  logic [3:0]       tcdm_gnt;
  logic [3:0][31:0] tcdm_add;
  logic [3:0]       tcdm_wen;
  logic [3:0][3:0]  tcdm_be;
  logic [3:0][31:0] tcdm_data;
  logic [3:0][31:0] tcdm_r_data;
  logic [3:0]       tcdm_r_valid;
  logic             oor_o;

  int total;
  int bad;

  snax_tcdm_responder #(
    .MP         (4),
    .NB_BANKS   (4),
    .BANK_WORDS (256),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tcdm_req     (tcdm_req),
    .tcdm_gnt     (tcdm_gnt),
    .tcdm_add     (tcdm_add),
    .tcdm_wen     (tcdm_wen),
    .tcdm_be      (tcdm_be),
    .tcdm_data    (tcdm_data),
    .tcdm_r_data  (tcdm_r_data),
    .tcdm_r_valid (tcdm_r_valid),
    .oor_o        (oor_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    tcdm_req  = '0;
    tcdm_add  = '0;
    tcdm_wen  = '1;
    tcdm_be   = '0;
    tcdm_data = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] be, input logic [31:0] d);
    tcdm_req[p]  = 1'b1;
    tcdm_add[p]  = a;
    tcdm_wen[p]  = w;
    tcdm_be[p]   = be;
    tcdm_data[p] = d;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clr();
    for (int p = 0; p < 4; p++) set_port(p, 32'(4 * p), 1'b1, 4'hF, 32'h0);
    #1;
    total++;
    if (tcdm_gnt !== 4'h0) begin
      bad++; $display("FAIL reset_gnt got=%h exp=%h", tcdm_gnt, 4'h0);
    end
    total++;
    if (tcdm_r_valid !== 4'h0) begin
      bad++; $display("FAIL reset_r_valid got=%h exp=%h", tcdm_r_valid, 4'h0);
    end
    total++;
    if (tcdm_r_data !== 128'h0) begin
      bad++; $display("FAIL reset_r_data got=%h exp=0", tcdm_r_data);
    end
    total++;
    if (oor_o !== 1'b0) begin
      bad++; $display("FAIL reset_oor got=%b exp=0", oor_o);
    end
    clr();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_conflict();
    logic [3:0] exp_g;
    int cnt [4];
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    clr();
    for (int p = 0; p < 4; p++) set_port(p, 32'(32'h40 * p), 1'b0, 4'hF, 32'hC0DE_0000 + 32'(p));
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = 4'b0001 << (c % 4);
      total++;
      if (tcdm_gnt !== exp_g) begin
        bad++; $display("FAIL conflict_wr_gnt c=%0d got=%b exp=%b", c, tcdm_gnt, exp_g);
      end
      for (int p = 0; p < 4; p++) if (tcdm_gnt[p]) cnt[p]++;
      tick();
      total++;
      if (tcdm_r_valid !== exp_g) begin
        bad++; $display("FAIL conflict_wr_rvalid c=%0d got=%b exp=%b", c, tcdm_r_valid, exp_g);
      end
    end
    for (int p = 0; p < 4; p++) begin
      total++;
      if (cnt[p] !== 2) begin
        bad++; $display("FAIL conflict_share p=%0d got=%0d exp=2", p, cnt[p]);
      end
    end
    for (int p = 0; p < 4; p++) tcdm_wen[p] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_g = 4'b0001 << c;
      total++;
      if (tcdm_gnt !== exp_g) begin
        bad++; $display("FAIL conflict_rd_gnt c=%0d got=%b exp=%b", c, tcdm_gnt, exp_g);
      end
      tick();
      total++;
      if (tcdm_r_valid !== exp_g) begin
        bad++; $display("FAIL conflict_rd_rvalid c=%0d got=%b exp=%b", c, tcdm_r_valid, exp_g);
      end
      total++;
      if (tcdm_r_data[c] !== 32'hC0DE_0000 + 32'(c)) begin
        bad++; $display("FAIL conflict_rd_data c=%0d got=%h exp=%h", c, tcdm_r_data[c], 32'hC0DE_0000 + 32'(c));
      end
    end
    clr();
    tick();
    total++;
    if (tcdm_r_valid !== 4'h0) begin
      bad++; $display("FAIL conflict_idle_rvalid got=%b exp=0000", tcdm_r_valid);
    end
  endtask

  task automatic test_no_conflict();
    clr();
    for (int p = 0; p < 4; p++) set_port(p, 32'(32'h200 + 4 * p), 1'b0, 4'hF, 32'h5A00_0000 + 32'(p));
    #1;
    total++;
    if (tcdm_gnt !== 4'hF) begin
      bad++; $display("FAIL noconf_wr_gnt got=%b exp=1111", tcdm_gnt);
    end
    tick();
    total++;
    if (tcdm_r_valid !== 4'hF) begin
      bad++; $display("FAIL noconf_wr_rvalid got=%b exp=1111", tcdm_r_valid);
    end
    total++;
    if (tcdm_r_data !== 128'h0) begin
      bad++; $display("FAIL noconf_wr_rdata got=%h exp=0", tcdm_r_data);
    end
    for (int p = 0; p < 4; p++) tcdm_wen[p] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (tcdm_gnt !== 4'hF) begin
        bad++; $display("FAIL noconf_rd_gnt c=%0d got=%b exp=1111", c, tcdm_gnt);
      end
      tick();
      total++;
      if (tcdm_r_valid !== 4'hF) begin
        bad++; $display("FAIL noconf_rd_rvalid c=%0d got=%b exp=1111", c, tcdm_r_valid);
      end
      for (int p = 0; p < 4; p++) begin
        total++;
        if (tcdm_r_data[p] !== 32'h5A00_0000 + 32'(p)) begin
          bad++; $display("FAIL noconf_rd_data p=%0d got=%h exp=%h", p, tcdm_r_data[p], 32'h5A00_0000 + 32'(p));
        end
      end
    end
    clr();
    tick();
  endtask

  task automatic test_single();
    clr();
    set_port(0, 32'h10, 1'b0, 4'hF, 32'h1234_5678);
    #1;
    total++;
    if (tcdm_gnt !== 4'b0001) begin
      bad++; $display("FAIL single_wr_gnt got=%b exp=0001", tcdm_gnt);
    end
    tick();
    total++;
    if (tcdm_r_valid !== 4'b0001) begin
      bad++; $display("FAIL single_wr_rvalid got=%b exp=0001", tcdm_r_valid);
    end
    total++;
    if (tcdm_r_data[0] !== 32'h0) begin
      bad++; $display("FAIL single_wr_rdata got=%h exp=0", tcdm_r_data[0]);
    end
    set_port(0, 32'h10, 1'b1, 4'h0, 32'h0);
    #1;
    total++;
    if (tcdm_gnt !== 4'b0001) begin
      bad++; $display("FAIL single_rd_gnt got=%b exp=0001", tcdm_gnt);
    end
    tick();
    total++;
    if (tcdm_r_valid !== 4'b0001) begin
      bad++; $display("FAIL single_rd_rvalid got=%b exp=0001", tcdm_r_valid);
    end
    total++;
    if (tcdm_r_data[0] !== 32'h1234_5678) begin
      bad++; $display("FAIL single_rd_data got=%h exp=12345678", tcdm_r_data[0]);
    end
    clr();
    tick();
    total++;
    if (tcdm_r_valid !== 4'h0) begin
      bad++; $display("FAIL single_idle_rvalid got=%b exp=0000", tcdm_r_valid);
    end
  endtask

  task automatic test_partial();
    clr();
    set_port(0, 32'h20, 1'b0, 4'hF, 32'h1111_1111);
    tick();
    set_port(0, 32'h20, 1'b0, 4'b0010, 32'hAABB_CCDD);
    tick();
    set_port(0, 32'h20, 1'b1, 4'h0, 32'h0);
    tick();
    total++;
    if (tcdm_r_data[0] !== 32'h1111_CC11) begin
      bad++; $display("FAIL partial_data got=%h exp=1111cc11", tcdm_r_data[0]);
    end
    clr();
    tick();
  endtask

  task automatic test_oor();
    clr();
    set_port(0, 32'h1000, 1'b1, 4'h0, 32'h0);
    #1;
    total++;
    if (tcdm_gnt !== 4'b0001) begin
      bad++; $display("FAIL oor_rd_gnt got=%b exp=0001", tcdm_gnt);
    end
    total++;
    if (oor_o !== 1'b1) begin
      bad++; $display("FAIL oor_rd_flag got=%b exp=1", oor_o);
    end
    tick();
    total++;
    if (tcdm_r_valid !== 4'b0001 || tcdm_r_data[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL oor_rd_data got=%b/%h exp=0001/deadbeef", tcdm_r_valid, tcdm_r_data[0]);
    end
    set_port(0, 32'h1010, 1'b0, 4'hF, 32'hFFFF_FFFF);
    set_port(1, 32'h10, 1'b1, 4'h0, 32'h0);
    #1;
    total++;
    if (tcdm_gnt !== 4'b0011 || oor_o !== 1'b1) begin
      bad++; $display("FAIL oor_wr_gnt got=%b/%b exp=0011/1", tcdm_gnt, oor_o);
    end
    tick();
    total++;
    if (tcdm_r_data[0] !== 32'h0 || tcdm_r_data[1] !== 32'h1234_5678) begin
      bad++; $display("FAIL oor_wr_rdata got=%h/%h exp=0/12345678", tcdm_r_data[0], tcdm_r_data[1]);
    end
    clr();
    set_port(0, 32'h10, 1'b1, 4'h0, 32'h0);
    #1;
    total++;
    if (oor_o !== 1'b0) begin
      bad++; $display("FAIL oor_inrange_flag got=%b exp=0", oor_o);
    end
    tick();
    total++;
    if (tcdm_r_data[0] !== 32'h1234_5678) begin
      bad++; $display("FAIL oor_mem_kept got=%h exp=12345678", tcdm_r_data[0]);
    end
    clr();
    tick();
  endtask

  task automatic test_reset_pending();
    clr();
    set_port(1, 32'h10, 1'b1, 4'h0, 32'h0);
    tick();
    total++;
    if (tcdm_r_valid !== 4'b0010) begin
      bad++; $display("FAIL pend_rvalid got=%b exp=0010", tcdm_r_valid);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (tcdm_r_valid !== 4'h0 || tcdm_r_data !== 128'h0) begin
      bad++; $display("FAIL pend_async_clear got=%b/%h exp=0000/0", tcdm_r_valid, tcdm_r_data);
    end
    total++;
    if (tcdm_gnt !== 4'h0) begin
      bad++; $display("FAIL pend_gnt_in_reset got=%b exp=0000", tcdm_gnt);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    clr();
    for (int p = 0; p < 4; p++) set_port(p, 32'(32'h40 * p), 1'b1, 4'h0, 32'h0);
    #1;
    total++;
    if (tcdm_gnt !== 4'b0001) begin
      bad++; $display("FAIL pend_first_gnt got=%b exp=0001", tcdm_gnt);
    end
    tick();
    clr();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_conflict();
    test_no_conflict();
    test_single();
    test_partial();
    test_oor();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
